i2c_byte_master: RTL and testbench

- Byte-level I2C master engine fed by the ICE host-command path.
- Consumes the `i2c_speed` setting maintained by the basics/settings block. `i2c_addr` is not consumed; address bytes are ordinary WRITE commands.
- Executes one primitive command at a time (START, WRITE byte, READ byte, STOP) on open-drain SCL/SDA.
- Reports byte results and ACK status back to the upstream I2C command/response stage.

---
 rtl/i2c_byte_master_if.sv | 17 +
 rtl/i2c_byte_master.sv | 115 +++++++++++
 tb/tb_i2c_byte_master.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/i2c_byte_master_if.sv
// i2c_byte_master_if: command/response handshake plus open-drain SCL/SDA lines of the byte master.
// master modport is the engine side; slave modport is the host/line side.
interface i2c_byte_master_if;
    logic       cmd_valid, cmd_ready, cmd_rd_nak, done;
    logic [1:0] cmd;
    logic [7:0] cmd_wr_data, rd_data;
    logic       ack_received, bus_error;
    logic       scl_oe, sda_oe, scl_in, sda_in;
    modport master (
        input  cmd_valid, cmd, cmd_wr_data, cmd_rd_nak, scl_in, sda_in,
        output cmd_ready, done, rd_data, ack_received, bus_error, scl_oe, sda_oe
    );
    modport slave (
        output cmd_valid, cmd, cmd_wr_data, cmd_rd_nak, scl_in, sda_in,
        input  cmd_ready, done, rd_data, ack_received, bus_error, scl_oe, sda_oe
    );
endinterface

// File: rtl/i2c_byte_master.sv
// i2c_byte_master: one START/WRITE/READ/STOP primitive at a time on open-drain SCL/SDA, 4 ticks per bit.
// Define I2C_CLOCK_STRETCH_EN to honour slave clock stretching with a STRETCH_TIMEOUT bus error.
module i2c_byte_master #(
    parameter logic [15:0] STRETCH_TIMEOUT = 16'd50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        i2c_speed,
    output logic [7:0]        debug,
    i2c_byte_master_if.master bus
);
    typedef enum logic [3:0] {IDLE, START, WBIT, WACK, RBIT, RACK, STOP} state_t;
    state_t     state;
    logic [7:0] div, spd, sh;
    logic [2:0] bitcnt;
    logic [1:0] q;
    logic       nak, tick, freeze;
`ifdef I2C_CLOCK_STRETCH_EN
    logic [15:0] stretch;
    // Every Q1 releases SCL, so a low scl_in there means a slave is stretching.
    assign freeze = state != IDLE && q == 2'd1 && !bus.scl_in;
`else
    logic unused_stretch;
    assign unused_stretch = ^{bus.scl_in, STRETCH_TIMEOUT};
    assign freeze = 1'b0;
`endif
    assign tick  = !freeze && div == spd;
    assign debug = {bus.bus_error, 3'b000, state};
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= IDLE;
            div              <= 8'd0;
            spd              <= 8'd0;
            sh               <= 8'd0;
            bitcnt           <= 3'd0;
            q                <= 2'd0;
            nak              <= 1'b0;
            bus.cmd_ready    <= 1'b1;
            bus.done         <= 1'b0;
            bus.rd_data      <= 8'd0;
            bus.ack_received <= 1'b0;
            bus.bus_error    <= 1'b0;
            bus.scl_oe       <= 1'b0;
            bus.sda_oe       <= 1'b0;
`ifdef I2C_CLOCK_STRETCH_EN
            stretch          <= 16'd0;
`endif
        end else begin
            bus.done <= 1'b0;
`ifdef I2C_CLOCK_STRETCH_EN
            stretch <= (freeze && stretch != STRETCH_TIMEOUT) ? stretch + 16'd1 : 16'd0;
            if (freeze && stretch == STRETCH_TIMEOUT) begin
                state         <= IDLE;
                bus.scl_oe    <= 1'b0;
                bus.sda_oe    <= 1'b0;
                bus.done      <= 1'b1;
                bus.cmd_ready <= 1'b1;
                bus.bus_error <= 1'b1;
            end else
`endif
            if (state == IDLE) begin
                if (bus.cmd_valid) begin
                    // Q0 action of the new command is applied on the accept edge itself.
                    state         <= bus.cmd == 2'd0 ? START : bus.cmd == 2'd1 ? WBIT : bus.cmd == 2'd2 ? RBIT : STOP;
                    bus.sda_oe    <= bus.cmd == 2'd3 ? 1'b1 : bus.cmd == 2'd1 ? ~bus.cmd_wr_data[7] : 1'b0;
                    spd           <= i2c_speed;
                    div           <= 8'd0;
                    q             <= 2'd0;
                    bitcnt        <= 3'd7;
                    sh            <= bus.cmd_wr_data;
                    nak           <= bus.cmd_rd_nak;
                    bus.cmd_ready <= 1'b0;
                    if (bus.cmd == 2'd0) bus.bus_error <= 1'b0;
                end
            end else if (tick) begin
                div <= 8'd0;
                q   <= q + 2'd1;
                case (q)
                    2'd0: bus.scl_oe <= 1'b0;
                    2'd1: begin
                        if (state == START) bus.sda_oe <= 1'b1;
                        if (state == STOP) bus.sda_oe <= 1'b0;
                        if (state == WACK || state == RBIT) sh <= {sh[6:0], bus.sda_in};
                    end
                    2'd2: bus.scl_oe <= state != STOP;
                    default: begin
                        bitcnt <= bitcnt - 3'd1;
                        case (state)
                            WBIT: begin
                                sh         <= {sh[6:0], 1'b0};
                                bus.sda_oe <= bitcnt == 3'd0 ? 1'b0 : ~sh[6];
                                if (bitcnt == 3'd0) state <= WACK;
                            end
                            RBIT: begin
                                if (bitcnt == 3'd0) begin
                                    state      <= RACK;
                                    bus.sda_oe <= ~nak;
                                end
                            end
                            default: begin
                                state         <= IDLE;
                                bus.done      <= 1'b1;
                                bus.cmd_ready <= 1'b1;
                                if (state == WACK) bus.ack_received <= ~sh[0];
                                if (state == RACK) bus.rd_data <= sh;
                            end
                        endcase
                    end
                endcase
            end else if (!freeze) begin
                div <= div + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_i2c_byte_master.sv
// tb_i2c_byte_master: directed tests of the byte master against a simple open-drain slave model.
// Stretch tests are compiled in when I2C_CLOCK_STRETCH_EN is defined.
module tb_i2c_byte_master;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] i2c_speed = 8'd0;
    logic [7:0] debug;
    logic       slave_sda = 1'b1, slave_scl = 1'b1;
    logic       scl_line, sda_line;
    int         checks = 0, errors = 0;
    int         lat, extra;
    logic [8:0] rise_bits;
    logic       rise_oe, fall_hi, rise_hi;

    i2c_byte_master_if bus ();
    i2c_byte_master dut (.clk(clk), .rst(rst), .i2c_speed(i2c_speed), .debug(debug), .bus(bus));

    assign scl_line   = ~bus.scl_oe & slave_scl;
    assign sda_line   = ~bus.sda_oe & slave_sda;
    assign bus.scl_in = scl_line;
    assign bus.sda_in = sda_line;

    always #5 clk = ~clk;

    // sv[8-k] is what the slave puts on SDA after the k-th SCL falling edge of the command.
    task automatic run(input logic [1:0] c, input logic [7:0] wd, input logic nk, input logic [8:0] sv,
                       input logic [7:0] spd_after, input int hold_scl, input int budget);
        int   falls;
        logic pscl, psda;
        lat = -1; extra = 0; rise_bits = 9'd0; rise_oe = 1'b0; fall_hi = 1'b0; rise_hi = 1'b0; falls = 0;
        @(negedge clk);
        bus.cmd = c; bus.cmd_wr_data = wd; bus.cmd_rd_nak = nk; bus.cmd_valid = 1'b1;
        slave_sda = sv[8]; slave_scl = hold_scl == 0;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0; i2c_speed = spd_after;
        pscl = scl_line; psda = sda_line;
        for (int t = 1; t <= budget; t++) begin
            @(posedge clk); #1;
            if (t == hold_scl) slave_scl = 1'b1;
            if (pscl && !scl_line) begin
                falls++;
                if (falls <= 8) slave_sda = sv[8 - falls];
            end
            if (!pscl && scl_line) begin
                rise_bits = {rise_bits[7:0], sda_line};
                rise_oe   = bus.sda_oe;
            end
            if (scl_line && pscl && psda && !sda_line) fall_hi = 1'b1;
            if (scl_line && pscl && !psda && sda_line) rise_hi = 1'b1;
            pscl = scl_line; psda = sda_line;
            if (bus.done) begin
                lat = t;
                break;
            end
        end
        repeat (8) begin
            @(posedge clk); #1;
            if (bus.done) extra++;
        end
    endtask

    task automatic test_reset();
        int d = 0;
        #23;
        checks += 6;
        if (bus.scl_oe !== 1'b0 || bus.sda_oe !== 1'b0) begin errors++; $display("FAIL reset_lines: scl_oe=%b sda_oe=%b want 0 0", bus.scl_oe, bus.sda_oe); end
        if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus.cmd_ready); end
        if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
        if (bus.rd_data !== 8'h00 || bus.ack_received !== 1'b0) begin errors++; $display("FAIL reset_results: rd_data=%h ack=%b want 00 0", bus.rd_data, bus.ack_received); end
        if (bus.bus_error !== 1'b0) begin errors++; $display("FAIL reset_bus_error: got %b want 0", bus.bus_error); end
        if (debug !== 8'h00) begin errors++; $display("FAIL reset_debug: got %h want 00", debug); end
        @(negedge clk); rst = 1'b1;
        i2c_speed = 8'd99;
        run(2'd0, 8'h00, 1'b0, 9'h1FF, 8'd99, 0, 1000);
        @(negedge clk);
        bus.cmd = 2'd1; bus.cmd_wr_data = 8'h00; bus.cmd_valid = 1'b1;
        @(posedge clk); #1; bus.cmd_valid = 1'b0;
        repeat (350) @(posedge clk);
        #1;
        checks++;
        if (bus.cmd_ready !== 1'b0 || bus.scl_oe !== 1'b1 || bus.sda_oe !== 1'b1) begin errors++; $display("FAIL mid_write: ready=%b scl_oe=%b sda_oe=%b want 0 1 1", bus.cmd_ready, bus.scl_oe, bus.sda_oe); end
        @(negedge clk); rst = 1'b0; #1;
        checks++;
        if (bus.scl_oe !== 1'b0 || bus.sda_oe !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.done !== 1'b0 || debug !== 8'h00) begin
            errors++; $display("FAIL async_reset: scl_oe=%b sda_oe=%b ready=%b done=%b debug=%h want 0 0 1 0 00", bus.scl_oe, bus.sda_oe, bus.cmd_ready, bus.done, debug);
        end
        repeat (4) begin @(posedge clk); #1; if (bus.done) d++; end
        @(negedge clk); rst = 1'b1;
        repeat (20) begin @(posedge clk); #1; if (bus.done || bus.scl_oe || bus.sda_oe) d++; end
        checks++;
        if (d != 0) begin errors++; $display("FAIL reset_quiet: %0d cycles with done/line activity, want 0", d); end
    endtask

    task automatic test_start_stop();
        i2c_speed = 8'd99;
        run(2'd0, 8'h00, 1'b0, 9'h1FF, 8'd99, 0, 1000);
        checks += 4;
        if (lat != 400) begin errors++; $display("FAIL start_latency: got %0d want 400", lat); end
        if (fall_hi !== 1'b1) begin errors++; $display("FAIL start_condition: sda fall while scl high=%b want 1", fall_hi); end
        if (extra != 0) begin errors++; $display("FAIL start_done_once: extra pulses %0d want 0", extra); end
        if (bus.scl_oe !== 1'b1 || bus.sda_oe !== 1'b1 || bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL start_end_lines: scl_oe=%b sda_oe=%b ready=%b want 1 1 1", bus.scl_oe, bus.sda_oe, bus.cmd_ready); end
        run(2'd3, 8'h00, 1'b0, 9'h1FF, 8'd99, 0, 1000);
        checks += 3;
        if (lat != 400 || extra != 0) begin errors++; $display("FAIL stop_latency: got %0d extra %0d want 400 0", lat, extra); end
        if (rise_hi !== 1'b1) begin errors++; $display("FAIL stop_condition: sda rise while scl high=%b want 1", rise_hi); end
        if (bus.scl_oe !== 1'b0 || bus.sda_oe !== 1'b0) begin errors++; $display("FAIL stop_release: scl_oe=%b sda_oe=%b want 0 0", bus.scl_oe, bus.sda_oe); end
    endtask

    task automatic test_write_ack();
        i2c_speed = 8'd99;
        run(2'd0, 8'h00, 1'b0, 9'h1FF, 8'd99, 0, 1000);
        run(2'd1, 8'hA5, 1'b0, 9'h1FE, 8'd99, 0, 5000);
        slave_sda = 1'b1;
        checks += 4;
        if (lat != 3600) begin errors++; $display("FAIL write_latency: got %0d want 3600", lat); end
        if (rise_bits !== 9'h14A) begin errors++; $display("FAIL write_ack_bits: got %h want 14a", rise_bits); end
        if (bus.ack_received !== 1'b1) begin errors++; $display("FAIL write_ack: got %b want 1", bus.ack_received); end
        if (fall_hi || rise_hi) begin errors++; $display("FAIL write_glitch: sda moved while scl high (fall %b rise %b) want 0 0", fall_hi, rise_hi); end
    endtask

    task automatic test_write_nak();
        i2c_speed = 8'd3;
        run(2'd1, 8'h3C, 1'b0, 9'h1FF, 8'd50, 0, 1000);
        checks += 3;
        if (lat != 144) begin errors++; $display("FAIL nak_latency_speed_latched: got %0d want 144", lat); end
        if (rise_bits !== 9'h079) begin errors++; $display("FAIL write_nak_bits: got %h want 079", rise_bits); end
        if (bus.ack_received !== 1'b0) begin errors++; $display("FAIL write_nak: got %b want 0", bus.ack_received); end
    endtask

    task automatic test_read();
        i2c_speed = 8'd3;
        run(2'd2, 8'h00, 1'b1, {8'h5A, 1'b1}, 8'd3, 0, 1000);
        checks += 4;
        if (lat != 144) begin errors++; $display("FAIL read_latency: got %0d want 144", lat); end
        if (bus.rd_data !== 8'h5A) begin errors++; $display("FAIL read_nak_data: got %h want 5a", bus.rd_data); end
        if (rise_oe !== 1'b0) begin errors++; $display("FAIL read_nak_slot: sda_oe=%b want 0", rise_oe); end
        if (bus.ack_received !== 1'b0) begin errors++; $display("FAIL read_keeps_ack: got %b want 0", bus.ack_received); end
        run(2'd2, 8'h00, 1'b0, {8'hC3, 1'b1}, 8'd3, 0, 1000);
        checks += 2;
        if (bus.rd_data !== 8'hC3) begin errors++; $display("FAIL read_ack_data: got %h want c3", bus.rd_data); end
        if (rise_oe !== 1'b1) begin errors++; $display("FAIL read_ack_slot: sda_oe=%b want 1", rise_oe); end
    endtask

    task automatic test_back_to_back();
        int d = 0;
        i2c_speed = 8'd0;
        @(negedge clk);
        bus.cmd = 2'd3; bus.cmd_valid = 1'b1;
        @(posedge clk);
        for (int t = 1; t <= 20; t++) begin
            @(posedge clk); #1;
            if (bus.done) d++;
        end
        bus.cmd_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checks += 2;
        if (d != 4) begin errors++; $display("FAIL back_to_back: got %0d done pulses in 20 clk want 4", d); end
        if (bus.cmd_ready !== 1'b1 || bus.scl_oe !== 1'b0 || bus.sda_oe !== 1'b0) begin errors++; $display("FAIL back_to_back_idle: ready=%b scl_oe=%b sda_oe=%b want 1 0 0", bus.cmd_ready, bus.scl_oe, bus.sda_oe); end
    endtask

`ifdef I2C_CLOCK_STRETCH_EN
    task automatic test_stretch();
        i2c_speed = 8'd3;
        run(2'd0, 8'h00, 1'b0, 9'h1FF, 8'd3, 1000, 3000);
        checks++;
        if (lat != 1012) begin errors++; $display("FAIL stretch_resume: got %0d want 1012", lat); end
        run(2'd0, 8'h00, 1'b0, 9'h1FF, 8'd3, 60000, 60000);
        checks += 4;
        if (lat != 50005) begin errors++; $display("FAIL stretch_timeout_latency: got %0d want 50005", lat); end
        if (bus.bus_error !== 1'b1 || debug !== 8'h80) begin errors++; $display("FAIL stretch_bus_error: err=%b debug=%h want 1 80", bus.bus_error, debug); end
        if (bus.scl_oe !== 1'b0 || bus.sda_oe !== 1'b0) begin errors++; $display("FAIL stretch_release: scl_oe=%b sda_oe=%b want 0 0", bus.scl_oe, bus.sda_oe); end
        if (bus.rd_data !== 8'hC3 || bus.ack_received !== 1'b0) begin errors++; $display("FAIL stretch_results_kept: rd=%h ack=%b want c3 0", bus.rd_data, bus.ack_received); end
        slave_scl = 1'b1;
        run(2'd0, 8'h00, 1'b0, 9'h1FF, 8'd3, 0, 1000);
        checks++;
        if (bus.bus_error !== 1'b0 || lat != 16) begin errors++; $display("FAIL stretch_clear: err=%b lat=%0d want 0 16", bus.bus_error, lat); end
    endtask
`else
    task automatic test_no_stretch();
        i2c_speed = 8'd3;
        run(2'd0, 8'h00, 1'b0, 9'h1FF, 8'd3, 100000, 1000);
        slave_scl = 1'b1;
        checks += 2;
        if (lat != 16) begin errors++; $display("FAIL no_stretch_latency: got %0d want 16", lat); end
        if (bus.bus_error !== 1'b0) begin errors++; $display("FAIL no_stretch_bus_error: got %b want 0", bus.bus_error); end
    endtask
`endif

    initial begin
        bus.cmd_valid = 1'b0; bus.cmd = 2'd0; bus.cmd_wr_data = 8'h00; bus.cmd_rd_nak = 1'b0;
        test_reset();
        test_start_stop();
        test_write_ack();
        test_write_nak();
        test_read();
        test_back_to_back();
`ifdef I2C_CLOCK_STRETCH_EN
        test_stretch();
`else
        test_no_stretch();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
